ber_test_sequencer: RTL and testbench

BER_TEST_SEQUENCER -- requirements
Module: ber_test_sequencer

---
 rtl/ber_test_sequencer_if.sv | 31 +++
 rtl/ber_test_sequencer.sv | 118 +++++++++++
 tb/tb_ber_test_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ber_test_sequencer_if.sv
// Control/status bundle between a BER test controller (master) and the sequencer (slave).
interface ber_test_sequencer_if #(
    parameter int ERR_W = 16
) ();
    logic             start;
    logic             abort;
    logic             mode;
    logic [15:0]      window_words;
    logic [ERR_W-1:0] err_limit;
    logic             word_valid;
    logic [3:0]       word_errs;
    logic             gen_mode;
    logic             gen_sel;
    logic             gen_en;
    logic             busy;
    logic             done;
    logic             pass;
    logic [31:0]      bit_count;
    logic [ERR_W-1:0] err_total;
    logic             err_sat;

    modport master (
        output start, abort, mode, window_words, err_limit, word_valid, word_errs,
        input  gen_mode, gen_sel, gen_en, busy, done, pass, bit_count, err_total, err_sat
    );

    modport slave (
        input  start, abort, mode, window_words, err_limit, word_valid, word_errs,
        output gen_mode, gen_sel, gen_en, busy, done, pass, bit_count, err_total, err_sat
    );
endinterface

// File: rtl/ber_test_sequencer.sv
// BER test sequencer: warm-up, counted window of PRBS words, saturating error total, pass/fail.
// Define BER_EARLY_FAIL_EN to end a run as soon as the error total exceeds the limit.
module ber_test_sequencer #(
    parameter int SYNC_CYCLES = 16,
    parameter int ERR_W       = 16
) (
    input logic                 clock,
    input logic                 reset,
    ber_test_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SYNC, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [15:0]      sync_cnt;
    logic [15:0]      word_cnt;
    logic [15:0]      word_cnt_inc;
    logic [31:0]      bit_count;
    logic [31:0]      bits_per_word;
    logic [ERR_W-1:0] err_total;
    logic [ERR_W-1:0] err_next;
    logic [ERR_W:0]   err_sum;
    logic             err_over;
    logic             err_sat;
    logic             gen_mode;
    logic             done_q;
    logic             load;
    logic             count;

    // One extra bit on the sum exposes overflow so the total clamps instead of wrapping.
    always_comb begin
        err_sum       = {1'b0, err_total} + {{(ERR_W-3){1'b0}}, bus.word_errs};
        err_over      = err_sum[ERR_W];
        err_next      = err_over ? '1 : err_sum[ERR_W-1:0];
        word_cnt_inc  = word_cnt + 16'd1;
        bits_per_word = gen_mode ? 32'd13 : 32'd8;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        count      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next = SYNC;
                    load       = 1'b1;
                end
            end
            SYNC: begin
                if (sync_cnt == 16'(SYNC_CYCLES - 1))
                    state_next = (bus.window_words == 16'd0) ? DONE : RUN;
            end
            RUN: begin
                if (bus.word_valid) begin
                    count = 1'b1;
                    if (word_cnt_inc == bus.window_words)
                        state_next = DONE;
`ifdef BER_EARLY_FAIL_EN
                    else if (err_next > bus.err_limit)
                        state_next = DONE;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
        // Abort overrides everything, including a start or a word in the same cycle.
        if (bus.abort) begin
            state_next = IDLE;
            load       = 1'b0;
            count      = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_cnt  <= '0;
            word_cnt  <= '0;
            bit_count <= '0;
            err_total <= '0;
            err_sat   <= 1'b0;
            gen_mode  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q   <= (state_next == DONE) && (state != DONE);
            sync_cnt <= (state == SYNC && state_next == SYNC) ? sync_cnt + 16'd1 : 16'd0;
            if (load) begin
                gen_mode  <= bus.mode;
                word_cnt  <= '0;
                bit_count <= '0;
                err_total <= '0;
                err_sat   <= 1'b0;
            end else if (count) begin
                word_cnt  <= word_cnt_inc;
                bit_count <= bit_count + bits_per_word;
                err_total <= err_next;
                err_sat   <= err_sat | err_over;
            end
        end
    end

    assign bus.gen_mode  = gen_mode;
    assign bus.gen_en    = (state == SYNC) || (state == RUN);
    assign bus.busy      = (state == SYNC) || (state == RUN);
    assign bus.gen_sel   = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.pass      = (err_total <= bus.err_limit);
    assign bus.bit_count = bit_count;
    assign bus.err_total = err_total;
    assign bus.err_sat   = err_sat;
endmodule

// File: tb/tb_ber_test_sequencer.sv
// Randomized directed bench for ber_test_sequencer; expectations come from a word-level model.
module tb_ber_test_sequencer;
    localparam int SYNC_CYCLES = 16;
    localparam int ERR_W       = 4;
    localparam int ERR_MAX     = (1 << ERR_W) - 1;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fails;
    int   errs_q[$];
    int   r_cycles;

    ber_test_sequencer_if #(.ERR_W(ERR_W)) bus ();

    ber_test_sequencer #(.SYNC_CYCLES(SYNC_CYCLES), .ERR_W(ERR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no end of test, expected end before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.word_valid = 1'b0;
        bus.word_errs  = 4'd0;
    endtask

    // Runs one test from IDLE/DONE. Words take their errors from errs_q in order (0 once empty).
    // abort_after >= 0 aborts the run once that many words have been counted.
    task automatic apply_stimulus(input logic m, input int window, input int limit,
                                  input int gap_pct, input int abort_after);
        int   sum, words, bits, cyc, e, exp_err;
        logic finished, valid;
        sum = 0; words = 0; bits = 0;
        bus.mode         = m;
        bus.window_words = 16'(window);
        bus.err_limit    = ERR_W'(limit);
        bus.abort        = 1'b0;
        bus.word_valid   = 1'b0;
        bus.start        = 1'b1;
        tick();
        cyc = 1;
        bus.start = 1'b0;
        bus.mode  = ~m;
        check_output("start_busy", bus.busy, 1);
        check_output("start_gen_en", bus.gen_en, 1);
        check_output("start_gen_sel", bus.gen_sel, 1);
        check_output("start_gen_mode", bus.gen_mode, m);
        check_output("start_bits_clear", bus.bit_count, 0);
        check_output("start_err_clear", bus.err_total, 0);
        check_output("start_sat_clear", bus.err_sat, 0);
        for (int i = 0; i < SYNC_CYCLES; i++) begin
            bus.word_valid = 1'b1;
            bus.word_errs  = 4'($urandom_range(13));
            bus.start      = 1'($urandom_range(1));
            tick();
            cyc++;
        end
        bus.start      = 1'b0;
        bus.word_valid = 1'b0;
        check_output("sync_words_ignored", bus.bit_count, 0);
        finished = (window == 0);
        for (int budget = 0; !finished && budget < 4000; budget++) begin
            if (abort_after >= 0 && words == abort_after) break;
            check_output("run_busy", bus.busy, 1);
            check_output("run_no_done", bus.done, 0);
            valid = ($urandom_range(99) >= gap_pct);
            e = 0;
            if (valid && errs_q.size() > 0) e = errs_q.pop_front();
            bus.word_valid = valid;
            bus.word_errs  = 4'(e);
            bus.start      = ($urandom_range(5) == 0);
            tick();
            cyc++;
            if (valid) begin
                words++;
                sum  += e;
                bits += m ? 13 : 8;
            end
            finished = (words == window);
`ifdef BER_EARLY_FAIL_EN
            if (((sum > ERR_MAX) ? ERR_MAX : sum) > limit) finished = 1'b1;
`endif
        end
        idle_inputs();
        exp_err  = (sum > ERR_MAX) ? ERR_MAX : sum;
        r_cycles = cyc;
        if (abort_after >= 0 && !finished) begin
            bus.abort      = 1'b1;
            bus.word_valid = 1'b1;
            bus.word_errs  = 4'd3;
            tick();
            idle_inputs();
            check_output("abort_busy", bus.busy, 0);
            check_output("abort_gen_en", bus.gen_en, 0);
            check_output("abort_gen_sel", bus.gen_sel, 0);
            check_output("abort_no_done", bus.done, 0);
            check_output("abort_bits_hold", bus.bit_count, 32'(bits));
            check_output("abort_err_hold", bus.err_total, 32'(exp_err));
            tick();
            check_output("abort_still_no_done", bus.done, 0);
            check_output("abort_bits_hold2", bus.bit_count, 32'(bits));
        end else begin
            check_output("run_finished_in_budget", finished, 1);
            check_output("done_pulse", bus.done, 1);
            check_output("done_busy", bus.busy, 0);
            check_output("done_gen_en", bus.gen_en, 0);
            check_output("done_gen_sel", bus.gen_sel, 1);
            check_output("done_gen_mode", bus.gen_mode, m);
            check_output("done_bits", bus.bit_count, 32'(bits));
            check_output("done_err", bus.err_total, 32'(exp_err));
            check_output("done_sat", bus.err_sat, (sum > ERR_MAX));
            check_output("done_pass", bus.pass, (exp_err <= limit));
            tick();
            check_output("done_single_pulse", bus.done, 0);
            check_output("done_gen_sel_hold", bus.gen_sel, 1);
            check_output("done_bits_hold", bus.bit_count, 32'(bits));
            check_output("done_err_hold", bus.err_total, 32'(exp_err));
        end
        errs_q.delete();
    endtask

    initial begin
        int placed, p, w;
        n_checks = 0;
        n_fails  = 0;

        // Reset with junk on every input: all of it must be ignored.
        reset            = 1'b0;
        bus.start        = 1'b1;
        bus.abort        = 1'b0;
        bus.mode         = 1'b1;
        bus.window_words = 16'd5;
        bus.err_limit    = '0;
        bus.word_valid   = 1'b1;
        bus.word_errs    = 4'd7;
        repeat (3) tick();
        check_output("rst_busy", bus.busy, 0);
        check_output("rst_done", bus.done, 0);
        check_output("rst_gen_en", bus.gen_en, 0);
        check_output("rst_gen_sel", bus.gen_sel, 0);
        check_output("rst_gen_mode", bus.gen_mode, 0);
        check_output("rst_bits", bus.bit_count, 0);
        check_output("rst_err", bus.err_total, 0);
        check_output("rst_sat", bus.err_sat, 0);
        check_output("rst_pass", bus.pass, 1);
        reset = 1'b1;
        idle_inputs();
        tick();
        check_output("idle_after_rst", bus.busy, 0);

        // 100 clean PRBS-7 words back to back: done lands on cycle 117 counting busy's first cycle.
        apply_stimulus(1'b0, 100, 0, 0, -1);
        check_output("latency_done_cycle", r_cycles, 117);
        check_output("clean_bits_800", bus.bit_count, 800);

        // PRBS-13, three single-bit errors at random positions, limit 2.
        for (int i = 0; i < 10; i++) errs_q.push_back(0);
        placed = 0;
        while (placed < 3) begin
            p = $urandom_range(9);
            if (errs_q[p] == 0) begin
                errs_q[p] = 1;
                placed++;
            end
        end
        apply_stimulus(1'b1, 10, 2, 30, -1);
        check_output("prbs13_err3", bus.err_total, 3);
        check_output("prbs13_fail", bus.pass, 0);

        // Abort after five counted words.
        apply_stimulus(1'b0, 20, 15, 20, 5);
        check_output("abort_bits_40", bus.bit_count, 40);

        // Start and abort together in IDLE: abort wins.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        idle_inputs();
        check_output("start_abort_idle", bus.busy, 0);
        check_output("start_abort_gen_sel", bus.gen_sel, 0);
        tick();
        check_output("start_abort_still_idle", bus.busy, 0);

        // Empty window goes straight from warm-up to DONE.
        apply_stimulus(1'($urandom_range(1)), 0, 0, 0, -1);
        check_output("empty_done_cycle", r_cycles, SYNC_CYCLES + 1);
        check_output("empty_bits", bus.bit_count, 0);
        check_output("empty_pass", bus.pass, 1);

        // Saturation: two 13-error words in a 4-bit accumulator.
        errs_q.push_back(13);
        errs_q.push_back(13);
        apply_stimulus(1'($urandom_range(1)), 2, 15, 10, -1);
        check_output("sat_total", bus.err_total, 15);
        check_output("sat_flag", bus.err_sat, 1);

        // Error on word 3 of 50 with limit 1: early-fail builds stop there.
        errs_q = '{0, 0, 2};
        apply_stimulus(1'b0, 50, 1, 0, -1);
        check_output("word3_fail", bus.pass, 0);

        // Randomized runs restarting from DONE.
        for (int t = 0; t < 6; t++) begin
            w = $urandom_range(40, 1);
            for (int i = 0; i < w; i++)
                errs_q.push_back(($urandom_range(3) == 0) ? $urandom_range(3) : 0);
            apply_stimulus(1'($urandom_range(1)), w, $urandom_range(15), 25, -1);
        end

        // Reset in the middle of a run discards it without a done pulse.
        bus.mode         = 1'b1;
        bus.window_words = 16'd30;
        bus.err_limit    = 4'd15;
        bus.start        = 1'b1;
        tick();
        bus.start      = 1'b0;
        bus.word_valid = 1'b1;
        bus.word_errs  = 4'd2;
        repeat (SYNC_CYCLES + 3) tick();
        check_output("midrun_bits", bus.bit_count, 39);
        check_output("midrun_err", bus.err_total, 6);
        reset = 1'b0;
        repeat (2) tick();
        check_output("midrst_busy", bus.busy, 0);
        check_output("midrst_done", bus.done, 0);
        check_output("midrst_bits", bus.bit_count, 0);
        check_output("midrst_err", bus.err_total, 0);
        check_output("midrst_gen_mode", bus.gen_mode, 0);
        check_output("midrst_gen_sel", bus.gen_sel, 0);
        check_output("midrst_pass", bus.pass, 1);
        reset = 1'b1;
        idle_inputs();
        tick();
        check_output("after_rst_busy", bus.busy, 0);
        check_output("after_rst_done", bus.done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
